dense_readout: RTL and testbench

DENSE_READOUT -- requirements
Module: dense_readout

---
 rtl/dense_pkg.sv | 16 +
 rtl/lane_unpack.sv | 21 ++
 rtl/dense_readout.sv | 162 ++++++++++++++++
 tb/tb_dense_readout.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared definitions for the dense engine and its result readout.
package dense_pkg;

    localparam int unsigned LANES_MAX = 8;  // lanes physically present in a memory word
    localparam int unsigned LANE_W    = 3;  // lane-slice index width
    localparam int unsigned IDX_W     = 7;  // result index / count width

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_UNPACK = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

endpackage

// File: rtl/lane_unpack.sv
// Extracts one signed lane from a packed result word; lane 0 occupies the MSBs.
module lane_unpack
    import dense_pkg::*;
#(
    parameter int unsigned SIZE_1 = 11
) (
    input  logic [LANES_MAX*SIZE_1-1:0] packed_word,
    input  logic [LANE_W-1:0]           lane,
    output logic signed [SIZE_1-1:0]    value_c
);

    always_comb begin
        value_c = '0;
        for (int unsigned l = 0; l < LANES_MAX; l++) begin
            if (lane == LANE_W'(l)) begin
                value_c = packed_word[(LANES_MAX-1-l)*SIZE_1 +: SIZE_1];
            end
        end
    end

endmodule

// File: rtl/dense_readout.sv
// Streams packed dense-layer results out of memory one lane at a time and
// tracks the running argmax; STOP flags completion until en is dropped.
module dense_readout
    import dense_pkg::*;
#(
    parameter int unsigned SIZE_1           = 11,
    parameter int unsigned NUM_CONV         = 8,
    parameter int unsigned SIZE_address_pix = 13
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [SIZE_address_pix-1:0]   memstartzap,
    input  logic [IDX_W-1:0]              out,
    output logic                          re_p,
    output logic [SIZE_address_pix-1:0]   read_addressp,
    input  logic [LANES_MAX*SIZE_1-1:0]   qp,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic signed [SIZE_1-1:0]      o_data,
    output logic [IDX_W-1:0]              o_idx,
    output logic [IDX_W-1:0]              class_idx,
    output logic signed [SIZE_1-1:0]      class_val,
    output logic                          STOP
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_CONV - 1);

    state_t                          state, state_d;
    logic [LANE_W-1:0]               lane_q, lane_d;
    logic [LANES_MAX*SIZE_1-1:0]     word_q, word_d;
    logic                            en_armed;
    logic                            re_p_d, o_valid_d, stop_d;
    logic [SIZE_address_pix-1:0]     addr_d;
    logic signed [SIZE_1-1:0]        o_data_d, class_val_d;
    logic [IDX_W-1:0]                o_idx_d, class_idx_d;
    logic [LANES_MAX*SIZE_1-1:0]     src_word_c;
    logic [LANE_W-1:0]               src_lane_c;
    logic signed [SIZE_1-1:0]        lane_value_c;
    logic                            accept_c;

    // In WAIT the fresh memory word supplies lane 0; in UNPACK the held word supplies the next lane.
    assign src_word_c = (state == ST_WAIT) ? qp : word_q;
    assign src_lane_c = (state == ST_WAIT) ? lane_q : LANE_W'(lane_q + 1'b1);
    assign accept_c   = o_valid & o_ready;

    lane_unpack #(
        .SIZE_1 (SIZE_1)
    ) u_lane_unpack (
        .packed_word (src_word_c),
        .lane        (src_lane_c),
        .value_c     (lane_value_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            lane_q        <= '0;
            word_q        <= '0;
            en_armed      <= 1'b0;
            re_p          <= 1'b0;
            read_addressp <= '0;
            o_valid       <= 1'b0;
            o_data        <= '0;
            o_idx         <= '0;
            class_idx     <= '0;
            class_val     <= '0;
            STOP          <= 1'b0;
        end else begin
            state         <= state_d;
            lane_q        <= lane_d;
            word_q        <= word_d;
            en_armed      <= en_armed | ~en;
            re_p          <= re_p_d;
            read_addressp <= addr_d;
            o_valid       <= o_valid_d;
            o_data        <= o_data_d;
            o_idx         <= o_idx_d;
            class_idx     <= class_idx_d;
            class_val     <= class_val_d;
            STOP          <= stop_d;
        end
    end

    always_comb begin
        state_d     = state;
        lane_d      = lane_q;
        word_d      = word_q;
        re_p_d      = 1'b0;
        addr_d      = read_addressp;
        o_valid_d   = 1'b0;
        o_data_d    = o_data;
        o_idx_d     = o_idx;
        class_idx_d = class_idx;
        class_val_d = class_val;
        stop_d      = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                // A run only starts once en has been seen low since reset.
                ST_IDLE: begin
                    if (en_armed) begin
                        class_idx_d = '0;
                        class_val_d = '0;
                        o_idx_d     = '0;
                        lane_d      = '0;
                        if (out == '0) begin
                            state_d = ST_FIN;
                        end else begin
                            state_d = ST_ADDR;
                            re_p_d  = 1'b1;
                            addr_d  = memstartzap;
                        end
                    end
                end
                ST_ADDR: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    state_d   = ST_UNPACK;
                    word_d    = qp;
                    o_valid_d = 1'b1;
                    o_data_d  = lane_value_c;
                end
                ST_UNPACK: begin
                    o_valid_d = 1'b1;
                    if (accept_c) begin
                        if ((o_idx == '0) || (o_data > class_val)) begin
                            class_idx_d = o_idx;
                            class_val_d = o_data;
                        end
                        if (o_idx == IDX_W'(out - IDX_W'(1))) begin
                            state_d   = ST_FIN;
                            o_valid_d = 1'b0;
                        end else begin
                            o_idx_d = IDX_W'(o_idx + IDX_W'(1));
                            if (lane_q == LAST_LANE) begin
                                state_d   = ST_ADDR;
                                o_valid_d = 1'b0;
                                re_p_d    = 1'b1;
                                addr_d    = SIZE_address_pix'(read_addressp + 1'b1);
                                lane_d    = '0;
                            end else begin
                                lane_d   = LANE_W'(lane_q + 1'b1);
                                o_data_d = lane_value_c;
                            end
                        end
                    end
                end
                ST_FIN: begin
                    stop_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dense_readout.sv
// Randomized bench for dense_readout: two instances (8 and 3 lanes per word)
// checked against a lane-array memory model and a plain argmax reference.
`timescale 1ns/1ps
module tb_dense_readout;

    localparam int unsigned AW = 13;

    logic              clk = 1'b0;
    logic              rst_n, en8, en3, ready;
    logic [AW-1:0]     base_addr;
    logic [6:0]        out_n;
    logic              re_p8, re_p3, v8, v3, stop8, stop3;
    logic [AW-1:0]     ra8, ra3;
    logic [63:0]       qp8, qp3;
    logic signed [7:0] d8, d3, cv8, cv3;
    logic [6:0]        i8, i3, ci8, ci3;

    logic signed [7:0] mem_lane [256][8];
    int                chk, err;
    int                addr_q[$];
    int                idx_q[$];
    int                data_q[$];
    int                stab_viol = 0;
    logic              prev_stall = 1'b0;
    logic [6:0]        prev_idx = '0;
    logic signed [7:0] prev_data = '0;

    always #5 clk = ~clk;

    dense_readout #(.SIZE_1(8), .NUM_CONV(8), .SIZE_address_pix(AW)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .memstartzap(base_addr), .out(out_n),
        .re_p(re_p8), .read_addressp(ra8), .qp(qp8), .o_valid(v8), .o_ready(ready),
        .o_data(d8), .o_idx(i8), .class_idx(ci8), .class_val(cv8), .STOP(stop8)
    );

    dense_readout #(.SIZE_1(8), .NUM_CONV(3), .SIZE_address_pix(AW)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .memstartzap(base_addr), .out(out_n),
        .re_p(re_p3), .read_addressp(ra3), .qp(qp3), .o_valid(v3), .o_ready(ready),
        .o_data(d3), .o_idx(i3), .class_idx(ci3), .class_val(cv3), .STOP(stop3)
    );

    function automatic logic [63:0] pack_word(input logic [AW-1:0] a);
        logic [63:0] w;
        for (int l = 0; l < 8; l++) w[(7-l)*8 +: 8] = mem_lane[a[7:0]][l];
        return w;
    endfunction

    // One-cycle-latency memory for each instance.
    always @(posedge clk) begin
        if (re_p8) qp8 <= pack_word(ra8);
        if (re_p3) qp3 <= pack_word(ra3);
    end

    // Collects reads and accepted results; flags any change while stalled.
    always @(negedge clk) begin
        if (re_p8) addr_q.push_back(int'(ra8));
        if (re_p3) addr_q.push_back(int'(ra3));
        if (v8 && ready) begin idx_q.push_back(int'(i8)); data_q.push_back(int'(d8)); end
        if (v3 && ready) begin idx_q.push_back(int'(i3)); data_q.push_back(int'(d3)); end
        if (prev_stall && !((v8 && i8 == prev_idx && d8 == prev_data) ||
                            (v3 && i3 == prev_idx && d3 == prev_data))) stab_viol++;
        prev_stall = (v8 || v3) && !ready;
        prev_idx   = v8 ? i8 : i3;
        prev_data  = v8 ? d8 : d3;
    end

    // Reference: result k lives in word base + k/nc, lane k%nc.
    function automatic int ev(input int base, input int k, input int nc);
        return int'(mem_lane[(base + k / nc) % 256][k % nc]);
    endfunction

    function automatic void model_argmax(input int base, input int n, input int nc,
                                         output int bi, output int bv);
        bi = 0; bv = 0;
        for (int k = 0; k < n; k++) begin
            int v = ev(base, k, nc);
            if (k == 0 || v > bv) begin bi = k; bv = v; end
        end
    endfunction

    task automatic fill(input int base, input int nw);
        for (int a = base; a < base + nw; a++)
            for (int l = 0; l < 8; l++) mem_lane[a % 256][l] = 8'($urandom);
    endtask

    task automatic clear_mon();
        addr_q.delete(); idx_q.delete(); data_q.delete();
    endtask

    task automatic run(input bit sel, input int n, input int base, input bit rnd,
                       output int edges, output bit tmo);
        clear_mon();
        base_addr = AW'(base); out_n = 7'(n); ready = 1'b1;
        @(posedge clk); #1;
        if (sel) en3 = 1'b1; else en8 = 1'b1;
        edges = 0; tmo = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); edges++;
            #1 ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (stop8 || stop3) begin tmo = 1'b0; break; end
        end
    endtask

    task automatic end_run();
        @(posedge clk); #1 en8 = 1'b0; en3 = 1'b0; ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk++; if (re_p8 !== 1'b0) begin err++; $display("FAIL reset_re_p: got %0d want 0", re_p8); end
        chk++; if (v8 !== 1'b0) begin err++; $display("FAIL reset_o_valid: got %0d want 0", v8); end
        chk++; if (stop8 !== 1'b0) begin err++; $display("FAIL reset_STOP: got %0d want 0", stop8); end
        chk++; if (ra8 !== '0) begin err++; $display("FAIL reset_addr: got %0d want 0", ra8); end
        chk++; if (d8 !== '0 || i8 !== '0) begin err++; $display("FAIL reset_data_idx: got %0d/%0d want 0/0", d8, i8); end
        chk++; if (ci8 !== '0 || cv8 !== '0) begin err++; $display("FAIL reset_class: got %0d/%0d want 0/0", ci8, cv8); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_out10();
        int edges, bi, bv; bit tmo;
        fill(100, 2);
        run(1'b0, 10, 100, 1'b0, edges, tmo);
        chk++; if (tmo) begin err++; $display("FAIL out10_timeout: got no STOP want STOP"); end
        chk++; if (addr_q.size() != 2 || addr_q[0] != 100 || addr_q[1] != 101) begin
            err++; $display("FAIL out10_addrs: got %0d reads want 100,101", addr_q.size()); end
        chk++; if (idx_q.size() != 10) begin err++; $display("FAIL out10_count: got %0d want 10", idx_q.size()); end
        for (int k = 0; k < idx_q.size() && k < 10; k++) begin
            chk++; if (idx_q[k] != k || data_q[k] != ev(100, k, 8)) begin
                err++; $display("FAIL out10_res%0d: got idx=%0d data=%0d want idx=%0d data=%0d",
                                k, idx_q[k], data_q[k], k, ev(100, k, 8)); end
        end
        chk++; if (edges != 16) begin err++; $display("FAIL out10_latency: got %0d edges want 16", edges); end
        model_argmax(100, 10, 8, bi, bv);
        chk++; if (int'(ci8) != bi || int'(cv8) != bv) begin
            err++; $display("FAIL out10_class: got %0d/%0d want %0d/%0d", ci8, cv8, bi, bv); end
        @(posedge clk); #1 en8 = 1'b0;
        @(posedge clk); @(negedge clk);
        chk++; if (stop8 !== 1'b0 || v8 !== 1'b0) begin err++; $display("FAIL out10_en_low: got STOP=%0d valid=%0d want 0/0", stop8, v8); end
        end_run();
    endtask

    task automatic test_argmax_tie();
        int edges; bit tmo;
        int tv[8] = '{3, -5, 7, 7, -128, 2, 0, 1};
        for (int l = 0; l < 8; l++) mem_lane[100][l] = 8'(tv[l]);
        run(1'b0, 8, 100, 1'b0, edges, tmo);
        chk++; if (tmo || idx_q.size() != 8) begin err++; $display("FAIL tie_count: got %0d want 8", idx_q.size()); end
        chk++; if (ci8 !== 7'd2 || cv8 !== 8'sd7) begin err++; $display("FAIL tie_class: got %0d/%0d want 2/7", ci8, cv8); end
        end_run();
        chk++; if (ci8 !== 7'd2 || cv8 !== 8'sd7) begin err++; $display("FAIL tie_class_hold: got %0d/%0d want 2/7", ci8, cv8); end
    endtask

    task automatic test_out_zero();
        int edges; bit tmo;
        run(1'b0, 0, 100, 1'b0, edges, tmo);
        chk++; if (tmo || edges != 2) begin err++; $display("FAIL zero_stop_edge: got %0d want 2", edges); end
        chk++; if (addr_q.size() != 0 || idx_q.size() != 0) begin
            err++; $display("FAIL zero_no_read: got reads=%0d results=%0d want 0/0", addr_q.size(), idx_q.size()); end
        chk++; if (ci8 !== '0 || cv8 !== '0) begin err++; $display("FAIL zero_class: got %0d/%0d want 0/0", ci8, cv8); end
        end_run();
    endtask

    task automatic test_backpressure();
        bit seen;
        int sv0;
        fill(100, 2);
        clear_mon();
        sv0 = stab_viol;
        base_addr = AW'(100); out_n = 7'd12; ready = 1'b1;
        @(posedge clk); #1 en8 = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin @(negedge clk); if (v8 && i8 == 7'd2) seen = 1'b1; end
        chk++; if (!seen) begin err++; $display("FAIL bp_reach: got no idx 2 want idx 2"); end
        @(posedge clk); #1 ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk++; if (v8 !== 1'b1 || i8 !== 7'd3 || int'(d8) != ev(100, 3, 8)) begin
                err++; $display("FAIL bp_hold%0d: got valid=%0d idx=%0d data=%0d want 1/3/%0d", c, v8, i8, d8, ev(100, 3, 8)); end
        end
        @(posedge clk); #1 ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin @(negedge clk); if (stop8) seen = 1'b1; end
        chk++; if (!seen || idx_q.size() != 12) begin err++; $display("FAIL bp_count: got %0d want 12", idx_q.size()); end
        for (int k = 0; k < idx_q.size() && k < 12; k++) begin
            chk++; if (idx_q[k] != k || data_q[k] != ev(100, k, 8)) begin
                err++; $display("FAIL bp_res%0d: got idx=%0d data=%0d want idx=%0d data=%0d",
                                k, idx_q[k], data_q[k], k, ev(100, k, 8)); end
        end
        chk++; if (stab_viol != sv0) begin err++; $display("FAIL bp_stable: got %0d changes want 0", stab_viol - sv0); end
        end_run();
    endtask

    task automatic test_reset_mid();
        bit seen; int edges; bit tmo;
        fill(100, 2);
        clear_mon();
        base_addr = AW'(100); out_n = 7'd10; ready = 1'b1;
        @(posedge clk); #1 en8 = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin @(negedge clk); if (v8 && i8 == 7'd4) seen = 1'b1; end
        chk++; if (!seen) begin err++; $display("FAIL rstmid_reach: got no idx 4 want idx 4"); end
        #1 rst_n = 1'b0;
        #1;
        chk++; if (v8 !== 1'b0 || re_p8 !== 1'b0 || stop8 !== 1'b0) begin
            err++; $display("FAIL rstmid_flags: got valid=%0d re=%0d stop=%0d want 0/0/0", v8, re_p8, stop8); end
        chk++; if (ra8 !== '0 || d8 !== '0 || i8 !== '0) begin
            err++; $display("FAIL rstmid_data: got addr=%0d data=%0d idx=%0d want 0/0/0", ra8, d8, i8); end
        chk++; if (ci8 !== '0 || cv8 !== '0) begin err++; $display("FAIL rstmid_class: got %0d/%0d want 0/0", ci8, cv8); end
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        clear_mon();
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk++; if (addr_q.size() != 0 || idx_q.size() != 0 || stop8 !== 1'b0) begin
            err++; $display("FAIL rstmid_quiet: got reads=%0d results=%0d stop=%0d want 0/0/0", addr_q.size(), idx_q.size(), stop8); end
        end_run();
        run(1'b0, 6, 100, 1'b0, edges, tmo);
        chk++; if (tmo || idx_q.size() != 6 || data_q[5] != ev(100, 5, 8)) begin
            err++; $display("FAIL rstmid_rerun: got %0d results want 6", idx_q.size()); end
        end_run();
    endtask

    task automatic test_num_conv3();
        int edges, bi, bv; bit tmo;
        fill(100, 3);
        run(1'b1, 7, 100, 1'b0, edges, tmo);
        chk++; if (tmo || addr_q.size() != 3 || addr_q[0] != 100 || addr_q[1] != 101 || addr_q[2] != 102) begin
            err++; $display("FAIL nc3_addrs: got %0d reads want 100,101,102", addr_q.size()); end
        chk++; if (idx_q.size() != 7) begin err++; $display("FAIL nc3_count: got %0d want 7", idx_q.size()); end
        for (int k = 0; k < idx_q.size() && k < 7; k++) begin
            chk++; if (idx_q[k] != k || data_q[k] != ev(100, k, 3)) begin
                err++; $display("FAIL nc3_res%0d: got idx=%0d data=%0d want idx=%0d data=%0d",
                                k, idx_q[k], data_q[k], k, ev(100, k, 3)); end
        end
        chk++; if (edges != 15) begin err++; $display("FAIL nc3_latency: got %0d edges want 15", edges); end
        model_argmax(100, 7, 3, bi, bv);
        chk++; if (int'(ci3) != bi || int'(cv3) != bv) begin
            err++; $display("FAIL nc3_class: got %0d/%0d want %0d/%0d", ci3, cv3, bi, bv); end
        end_run();
    endtask

    task automatic test_random();
        int edges, bi, bv, nc, n, base, nw, sv0; bit tmo, sel;
        for (int r = 0; r < 8; r++) begin
            sel  = 1'($urandom_range(0, 1));
            nc   = sel ? 3 : 8;
            n    = $urandom_range(1, 40);
            base = $urandom_range(0, 150);
            nw   = (n + nc - 1) / nc;
            fill(base, nw + 1);
            sv0 = stab_viol;
            run(sel, n, base, 1'b1, edges, tmo);
            chk++; if (tmo || idx_q.size() != n) begin err++; $display("FAIL rnd%0d_count: got %0d want %0d", r, idx_q.size(), n); end
            for (int k = 0; k < idx_q.size() && k < n; k++) begin
                chk++; if (idx_q[k] != k || data_q[k] != ev(base, k, nc)) begin
                    err++; $display("FAIL rnd%0d_res%0d: got idx=%0d data=%0d want idx=%0d data=%0d",
                                    r, k, idx_q[k], data_q[k], k, ev(base, k, nc)); end
            end
            chk++; if (addr_q.size() != nw) begin err++; $display("FAIL rnd%0d_nreads: got %0d want %0d", r, addr_q.size(), nw); end
            for (int w = 0; w < addr_q.size() && w < nw; w++) begin
                chk++; if (addr_q[w] != base + w) begin
                    err++; $display("FAIL rnd%0d_addr%0d: got %0d want %0d", r, w, addr_q[w], base + w); end
            end
            model_argmax(base, n, nc, bi, bv);
            chk++; if ((sel ? int'(ci3) : int'(ci8)) != bi || (sel ? int'(cv3) : int'(cv8)) != bv) begin
                err++; $display("FAIL rnd%0d_class: got %0d/%0d want %0d/%0d", r,
                                sel ? ci3 : ci8, sel ? cv3 : cv8, bi, bv); end
            chk++; if (stab_viol != sv0) begin err++; $display("FAIL rnd%0d_stable: got %0d changes want 0", r, stab_viol - sv0); end
            end_run();
        end
    endtask

    initial begin
        chk = 0; err = 0;
        rst_n = 1'b0; en8 = 1'b0; en3 = 1'b0; ready = 1'b1;
        base_addr = '0; out_n = '0;
        test_reset();
        test_out10();
        test_argmax_tie();
        test_out_zero();
        test_backpressure();
        test_reset_mid();
        test_num_conv3();
        test_random();
        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

endmodule
